// File: rtl/mem_dma_master_pkg.sv
// Shared definitions for the memory-to-memory DMA initiator: default widths,
// FSM state encoding and the idle bus control word.
package mem_dma_master_pkg;

  localparam int DEF_AW = 9;
  localparam int DEF_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  typedef struct packed {
    logic we;
    logic cs;
    logic cs_o;
  } bus_ctl_t;

  // The memory writes whenever it is not a read, so "idle" must be a read.
  localparam bus_ctl_t BUS_IDLE = '{we: 1'b0, cs: 1'b1, cs_o: 1'b0};

endpackage

// File: rtl/mem_dma_master.sv
// Copies len bytes from src to dst over the synchronous memory bus using a
// read / capture / write cycle per byte, in strictly ascending address order.
module mem_dma_master
  import mem_dma_master_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] AB,
  output logic          WE,
  output logic          CS,
  output logic          CS_o,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  state_e        state_reg, state_next;
  logic [AW-1:0] src_ptr_reg, dst_ptr_reg, ab_reg, ab_mux;
  logic [AW:0]   remaining_reg;
  logic [DW-1:0] data_reg;
  bus_ctl_t      bus_ctl;
  logic          accept;

  assign accept = (state_reg == ST_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = (len == '0) ? ST_FIN : ST_RD;
      ST_RD:   state_next = ST_CAP;
      ST_CAP:  state_next = ST_WR;
      ST_WR:   state_next = (remaining_reg == (AW+1)'(1)) ? ST_FIN : ST_RD;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outside RD/CAP/WR the address simply repeats whatever was last driven.
  always_comb begin
    bus_ctl = BUS_IDLE;
    ab_mux  = ab_reg;
    busy    = (state_reg != ST_IDLE);
    done    = (state_reg == ST_FIN);
    case (state_reg)
      ST_RD:  ab_mux = src_ptr_reg;
      ST_CAP: begin
        ab_mux       = src_ptr_reg;
        bus_ctl.cs_o = 1'b1;
      end
      ST_WR:  begin
        ab_mux     = dst_ptr_reg;
        bus_ctl.we = 1'b1;
      end
      default: ;
    endcase
  end

  assign AB     = ab_mux;
  assign WE     = bus_ctl.we;
  assign CS     = bus_ctl.cs;
  assign CS_o   = bus_ctl.cs_o;
  assign mem_wd = data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr_reg   <= '0;
      dst_ptr_reg   <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
      ab_reg        <= '0;
    end else begin
      ab_reg <= ab_mux;
      if (accept) begin
        src_ptr_reg   <= src;
        dst_ptr_reg   <= dst;
        remaining_reg <= len;
      end
      if (state_reg == ST_CAP) begin
        data_reg <= mem_rd;
      end
      // Pointers wrap naturally at 2**AW.
      if (state_reg == ST_WR) begin
        src_ptr_reg   <= src_ptr_reg + 1'b1;
        dst_ptr_reg   <= dst_ptr_reg + 1'b1;
        remaining_reg <= remaining_reg - 1'b1;
      end
    end
  end

endmodule
